// File: rtl/control_seq.sv
// Instruction sequencer: fetches a 16-bit word, decodes it into datapath control fields,
// and steps through EXEC/MEM/WB with a bounded wait on data memory and a sticky fault state.
module control_seq #(
  parameter int DW          = 16,
  parameter bit SEXT        = 1'b1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [15:0]   IR,
  input  logic          IR_VALID,
  output logic          IR_READY,
  input  logic          MEM_DONE,
  input  logic          COND,
  output logic [2:0]    DA,
  output logic [2:0]    AA,
  output logic [2:0]    BA,
  output logic [4:0]    FS,
  output logic          MB,
  output logic [DW-1:0] KNS,
  output logic          RW,
  output logic          MR,
  output logic          MW,
  output logic          MD,
  output logic          PL,
  output logic          PI,
  output logic          FAULT,
  output logic [1:0]    FAULT_CODE,
  output logic [2:0]    DBG_STATE
);

  // Handshake: a word is transferred on a rising CLK edge where IR_VALID and IR_READY are
  // both 1 and RST is 0; IR_READY never depends on IR_VALID.

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [4:0] FS_ADD  = 5'b00010;
  localparam logic [4:0] FS_SUB  = 5'b00101;
  localparam logic [4:0] FS_AND  = 5'b01000;
  localparam logic [4:0] FS_OR   = 5'b01010;
  localparam logic [4:0] FS_XOR  = 5'b01100;
  localparam logic [4:0] FS_PASS = 5'b01110;
  localparam logic [7:0] TMO     = MEM_TIMEOUT[7:0];

  function automatic logic [DW-1:0] lit8(input logic [7:0] v);
    return {{(DW-8){SEXT & v[7]}}, v};
  endfunction

  function automatic logic [DW-1:0] lit11(input logic [10:0] v);
    return {{(DW-11){SEXT & v[10]}}, v};
  endfunction

  function automatic logic [DW-1:0] off12(input logic [11:0] v);
    return {{(DW-12){v[11]}}, v};
  endfunction

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  code_q, code_d;

  logic illegal, is_ld, is_st, is_brc, is_jmp;

  // Field decode works from the latched word only, so fields hold until the next handshake.
  // A cleared word decodes as illegal, which leaves every field at 0.
  always_comb begin
    DA      = 3'd0;
    AA      = 3'd0;
    BA      = 3'd0;
    FS      = 5'd0;
    MB      = 1'b0;
    KNS     = '0;
    illegal = 1'b0;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    is_brc  = 1'b0;
    is_jmp  = 1'b0;
    case (ir_q[15:14])
      2'b00: begin
        case (ir_q[13:11])
          3'd1:    FS = FS_ADD;
          3'd2:    FS = FS_SUB;
          3'd3:    FS = FS_AND;
          3'd4:    FS = FS_OR;
          3'd5:    FS = FS_XOR;
          default: illegal = 1'b1;
        endcase
        if (!illegal) begin
          DA  = ir_q[10:8];
          AA  = ir_q[10:8];
          MB  = 1'b1;
          KNS = lit8(ir_q[7:0]);
        end
      end
      2'b01: begin
        FS = ir_q[13:9];
        DA = ir_q[8:6];
        AA = ir_q[5:3];
        BA = ir_q[2:0];
      end
      2'b10: begin
        case (ir_q[13:12])
          2'b00: begin
            is_ld = 1'b1;
            DA    = ir_q[8:6];
            AA    = ir_q[5:3];
          end
          2'b01: begin
            is_st = 1'b1;
            AA    = ir_q[5:3];
            BA    = ir_q[2:0];
          end
          2'b10: begin
            is_brc = 1'b1;
            KNS    = off12(ir_q[11:0]);
          end
          default: begin
            is_jmp = 1'b1;
            KNS    = off12(ir_q[11:0]);
          end
        endcase
      end
      default: begin
        DA  = ir_q[13:11];
        MB  = 1'b1;
        FS  = FS_PASS;
        KNS = lit11(ir_q[10:0]);
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    IR_READY = 1'b0;
    RW       = 1'b0;
    MR       = 1'b0;
    MW       = 1'b0;
    MD       = 1'b0;
    PL       = 1'b0;
    PI       = 1'b0;
    case (state_q)
      S_FETCH: begin
        IR_READY = ~RST;
        if (IR_VALID) begin
          ir_d    = IR;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          state_d = S_FAULT;
          code_d  = 2'b01;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_d = 8'd0;
        if (is_ld || is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_FETCH;
          if (is_jmp) begin
            PL = 1'b1;
          end else if (is_brc) begin
            PL = COND;
            PI = ~COND;
          end else begin
            RW = 1'b1;
            PI = 1'b1;
          end
        end
      end
      S_MEM: begin
        MR = is_ld;
        MW = is_st;
        // Completion wins over timeout when both happen in the same cycle.
        if (MEM_DONE) begin
          if (is_ld) begin
            state_d = S_WB;
          end else begin
            PI      = 1'b1;
            state_d = S_FETCH;
          end
        end else if (cnt_q + 8'd1 == TMO) begin
          state_d = S_FAULT;
          code_d  = 2'b10;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        RW      = 1'b1;
        MD      = 1'b1;
        PI      = 1'b1;
        state_d = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_FETCH;
      ir_q    <= 16'd0;
      cnt_q   <= 8'd0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  assign FAULT      = (state_q == S_FAULT);
  assign FAULT_CODE = code_q;
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_control_seq.sv
// Bench for control_seq: directed scenarios plus random instructions checked against a
// transaction-level model of the decode fields and per-phase strobes.
module tb_control_seq;

  localparam int TMO = 15;
  localparam logic [2:0] K_WR = 3'd0, K_JMP = 3'd1, K_BRC = 3'd2,
                         K_LD = 3'd3, K_ST = 3'd4, K_ILL = 3'd5;

  typedef struct packed {
    logic [2:0]  da, aa, ba;
    logic [4:0]  fs;
    logic        mb;
    logic [15:0] k1, k0;
    logic [2:0]  kind;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] IR = 16'd0;
  logic        IR_VALID = 1'b0, MEM_DONE = 1'b0, COND = 1'b0;
  logic        IR_READY, MB, RW, MR, MW, MD, PL, PI, FAULT;
  logic [2:0]  DA, AA, BA, DBG_STATE;
  logic [4:0]  FS;
  logic [15:0] KNS;
  logic [1:0]  FAULT_CODE;
  logic        z_rdy, z_mb, z_rw, z_mr, z_mw, z_md, z_pl, z_pi, z_fault;
  logic [2:0]  z_da, z_aa, z_ba, z_dbg;
  logic [4:0]  z_fs;
  logic [15:0] z_kns;
  logic [1:0]  z_code;
  int          total = 0;
  int          bad = 0;

  wire [5:0] stb = {RW, MR, MW, MD, PL, PI};

  always #5 CLK = ~CLK;

  control_seq #(.DW(16), .SEXT(1'b1), .MEM_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .IR(IR), .IR_VALID(IR_VALID), .IR_READY(IR_READY),
    .MEM_DONE(MEM_DONE), .COND(COND), .DA(DA), .AA(AA), .BA(BA), .FS(FS), .MB(MB),
    .KNS(KNS), .RW(RW), .MR(MR), .MW(MW), .MD(MD), .PL(PL), .PI(PI), .FAULT(FAULT),
    .FAULT_CODE(FAULT_CODE), .DBG_STATE(DBG_STATE)
  );

  control_seq #(.DW(16), .SEXT(1'b0), .MEM_TIMEOUT(TMO)) dut0 (
    .CLK(CLK), .RST(RST), .IR(IR), .IR_VALID(IR_VALID), .IR_READY(z_rdy),
    .MEM_DONE(MEM_DONE), .COND(COND), .DA(z_da), .AA(z_aa), .BA(z_ba), .FS(z_fs), .MB(z_mb),
    .KNS(z_kns), .RW(z_rw), .MR(z_mr), .MW(z_mw), .MD(z_md), .PL(z_pl), .PI(z_pi),
    .FAULT(z_fault), .FAULT_CODE(z_code), .DBG_STATE(z_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  function automatic logic [4:0] alu_code(input logic [2:0] op);
    case (op)
      3'd1:    return 5'b00010;
      3'd2:    return 5'b00101;
      3'd3:    return 5'b01000;
      3'd4:    return 5'b01010;
      default: return 5'b01100;
    endcase
  endfunction

  // Extension by arithmetic: (v xor signbit) - signbit sign-extends a w-bit value.
  function automatic exp_t model(input logic [15:0] ir);
    exp_t e;
    int   v;
    e = '0;
    case (ir[15:14])
      2'd0: begin
        if (ir[13:11] >= 3'd1 && ir[13:11] <= 3'd5) begin
          e.kind = K_WR;
          e.da = ir[10:8];
          e.aa = ir[10:8];
          e.mb = 1'b1;
          e.fs = alu_code(ir[13:11]);
          v = int'(ir[7:0]);
          e.k0 = 16'(v);
          e.k1 = 16'((v ^ 128) - 128);
        end else begin
          e.kind = K_ILL;
        end
      end
      2'd1: begin
        e.kind = K_WR;
        e.fs = ir[13:9];
        e.da = ir[8:6];
        e.aa = ir[5:3];
        e.ba = ir[2:0];
      end
      2'd3: begin
        e.kind = K_WR;
        e.da = ir[13:11];
        e.mb = 1'b1;
        e.fs = 5'b01110;
        v = int'(ir[10:0]);
        e.k0 = 16'(v);
        e.k1 = 16'((v ^ 1024) - 1024);
      end
      default: begin
        v = int'(ir[11:0]);
        case (ir[13:12])
          2'd0: begin e.kind = K_LD; e.da = ir[8:6]; e.aa = ir[5:3]; end
          2'd1: begin e.kind = K_ST; e.aa = ir[5:3]; e.ba = ir[2:0]; end
          2'd2: begin e.kind = K_BRC; e.k1 = 16'((v ^ 2048) - 2048); e.k0 = e.k1; end
          default: begin e.kind = K_JMP; e.k1 = 16'((v ^ 2048) - 2048); e.k0 = e.k1; end
        endcase
      end
    endcase
    return e;
  endfunction

  // Strobes {RW,MR,MW,MD,PL,PI} in the EXEC cycle.
  function automatic logic [5:0] exec_stb(input logic [2:0] kind, input logic c);
    case (kind)
      K_WR:    return 6'b100001;
      K_JMP:   return 6'b000010;
      K_BRC:   return c ? 6'b000010 : 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic chk_fields(input string ph, input exp_t e);
    chk({ph, "_da"}, 32'(DA), 32'(e.da));
    chk({ph, "_aa"}, 32'(AA), 32'(e.aa));
    chk({ph, "_ba"}, 32'(BA), 32'(e.ba));
    chk({ph, "_fs"}, 32'(FS), 32'(e.fs));
    chk({ph, "_mb"}, 32'(MB), 32'(e.mb));
    chk({ph, "_kns"}, 32'(KNS), 32'(e.k1));
    chk({ph, "_kns_zext"}, 32'(z_kns), 32'(e.k0));
  endtask

  task automatic chk_fault_hold(input logic [1:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      IR_VALID = 1'b1;
      MEM_DONE = 1'b1;
      #1;
      chk("fault_flag", 32'(FAULT), 32'd1);
      chk("fault_code", 32'(FAULT_CODE), 32'(code));
      chk("fault_stb", 32'(stb), 32'd0);
      chk("fault_rdy", 32'(IR_READY), 32'd0);
      cyc();
    end
    IR_VALID = 1'b0;
    MEM_DONE = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    IR_VALID = 1'b1;
    IR = 16'h0901;
    MEM_DONE = 1'b0;
    COND = 1'b0;
    cyc();
    cyc();
    RST = 1'b0;
    IR_VALID = 1'b0;
    #1;
    chk("rst_rdy", 32'(IR_READY), 32'd1);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_fields", {DA, AA, BA, FS, MB}, 32'd0);
    chk("rst_kns", 32'(KNS), 32'd0);
    chk("rst_kns_zext", 32'(z_kns), 32'd0);
    chk("rst_fault", {FAULT, FAULT_CODE}, 32'd0);
  endtask

  // d: MEM cycle (1-based) in which MEM_DONE is raised; 0 means never.
  task automatic run_instr(input logic [15:0] ir, input logic c, input int d);
    exp_t e;
    logic [5:0] m;
    e = model(ir);
    IR = ir;
    IR_VALID = 1'b1;
    MEM_DONE = 1'b0;
    COND = 1'b0;
    #1;
    chk("fetch_rdy", 32'(IR_READY), 32'd1);
    cyc();
    IR_VALID = 1'b0;
    IR = 16'($urandom);
    #1;
    chk("dec_rdy", 32'(IR_READY), 32'd0);
    chk("dec_stb", 32'(stb), 32'd0);
    chk_fields("dec", e);
    cyc();
    if (e.kind == K_ILL) begin
      chk_fault_hold(2'b01, 3);
      return;
    end
    COND = c;
    #1;
    chk("exec_stb", 32'(stb), 32'(exec_stb(e.kind, c)));
    chk_fields("exec", e);
    if (e.kind == K_LD || e.kind == K_ST) begin
      for (int i = 1; i <= TMO; i++) begin
        cyc();
        MEM_DONE = (i == d);
        #1;
        m = (e.kind == K_LD) ? 6'b010000 : {5'b00100, (i == d)};
        chk("mem_stb", 32'(stb), 32'(m));
        if (i == d) break;
      end
      cyc();
      MEM_DONE = 1'b0;
      if (d == 0) begin
        chk_fault_hold(2'b10, 4);
        return;
      end
      if (e.kind == K_LD) begin
        #1;
        chk("wb_stb", 32'(stb), 32'b100101);
        chk("wb_da_aa", {DA, AA}, {e.da, e.aa});
        cyc();
      end
    end else begin
      cyc();
    end
    COND = 1'b0;
    #1;
    chk("back_rdy", 32'(IR_READY), 32'd1);
    chk("back_stb", 32'(stb), 32'd0);
  endtask

  initial begin
    logic [15:0] r, ir;
    int c, dly;

    do_reset();

    run_instr(16'h0901, 1'b0, 0);
    chk("addi_kns", 32'(KNS), 32'h0001);

    run_instr(16'hDC00, 1'b0, 0);
    chk("ldi_da", 32'(DA), 32'd3);
    chk("ldi_kns_sext", 32'(KNS), 32'hFC00);
    chk("ldi_kns_zext", 32'(z_kns), 32'h0400);

    run_instr(16'h8048, 1'b0, 4);
    run_instr(16'hA005, 1'b1, 0);
    chk("brc_kns", 32'(KNS), 32'd5);
    run_instr(16'hA005, 1'b0, 0);
    run_instr(16'hBFFF, 1'b1, 0);
    run_instr(16'h5A53, 1'b0, 0);
    run_instr(16'h2C85, 1'b0, 0);
    run_instr(16'h901A, 1'b0, TMO);
    run_instr(16'h8F3F, 1'b0, 1);

    // Reset in the second MEM cycle of a load.
    IR = 16'h8048;
    IR_VALID = 1'b1;
    cyc();
    IR_VALID = 1'b0;
    cyc();
    cyc();
    cyc();
    #1;
    chk("rstmem_mr", 32'(MR), 32'd1);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    #1;
    chk("rstmem_stb", 32'(stb), 32'd0);
    chk("rstmem_rdy", 32'(IR_READY), 32'd1);
    run_instr(16'h0A7F, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      c = $urandom_range(0, 3);
      r = 16'($urandom);
      if (c == 0) ir = {2'b00, 3'($urandom_range(1, 5)), r[10:0]};
      else ir = {2'(c), r[13:0]};
      dly = $urandom_range(1, TMO);
      run_instr(ir, 1'($urandom_range(0, 1)), dly);
    end

    run_instr(16'h0000, 1'b0, 0);
    do_reset();
    run_instr(16'h3123, 1'b0, 0);
    do_reset();
    run_instr(16'h38FF, 1'b0, 0);
    do_reset();

    run_instr(16'h9011, 1'b0, 0);
    do_reset();
    run_instr(16'h0901, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_seq.md
CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 Parameter DW, default 16: datapath width; all literals and branch offsets SHALL be extended to DW bits.
REQ-002 Parameter SEXT, default 1: 1 sign-extends literals, 0 zero-extends; branch offsets SHALL always be sign-extended.
REQ-003 Parameter MEM_TIMEOUT, default 15, range 1..255: maximum cycles spent waiting for MEM_DONE.
REQ-004 The block SHALL use one clock; reset SHALL be synchronous and active-high; the ports SHALL be named CLK and RST.
REQ-005 CLK  in  1  rising-edge clock.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 IR  in  16  instruction word, sampled on the IR_VALID&IR_READY handshake.
REQ-008 IR_VALID  in  1  instruction-memory word available; IR_READY  out  1  sequencer accepts a word.
REQ-009 MEM_DONE  in  1  data-memory access complete; COND  in  1  datapath branch condition.
REQ-010 DA, AA, BA  out  3 each  destination, A-source and B-source register addresses.
REQ-011 FS  out  5  function select; MB  out  1  B-operand mux selects constant; KNS  out  DW  extended constant.
REQ-012 RW, MR, MW, MD, PL, PI  out  1 each  register write, memory read, memory write, writeback-from-memory select, PC load, PC increment.
REQ-013 FAULT  out  1  sticky fault; FAULT_CODE  out  2  01 illegal opcode, 10 memory timeout.

Function
REQ-014 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB and FAULT.
REQ-015 IR_READY SHALL be 1 only in FETCH; the handshake SHALL latch IR internally and move to DECODE.
REQ-016 In DECODE, DA/AA/BA/FS/MB/KNS SHALL be driven from the latched IR, all strobes SHALL be 0, and these fields SHALL hold until the next handshake.
REQ-017 Class 00 (IR[15:14]=00), for op IR[13:11] = 001/010/011/100/101 (ADDI/SUBI/ANDI/ORI/XORI):
- DA=AA=IR[10:8], MB=1, KNS=ext(IR[7:0]).
- FS SHALL be the fixed ALU code for ADD/SUB/AND/OR/XOR.
REQ-018 Class 00 ops 000, 110 and 111 SHALL go DECODE->FAULT with FAULT_CODE=01.
REQ-019 Class 01: FS=IR[13:9], DA=IR[8:6], AA=IR[5:3], BA=IR[2:0], MB=0.
REQ-020 Class 11 (LDI): DA=IR[13:11], KNS=ext(IR[10:0]), MB=1, FS SHALL be the pass-B code.
REQ-021 Class 10 subop IR[13:12]:
- 00 LD: DA=IR[8:6], AA=IR[5:3].
- 01 ST: AA=IR[5:3] (address), BA=IR[2:0] (data).
- 10 BRC and 11 JMP: KNS=sext(IR[11:0]).
REQ-022 EXEC for ALU, LDI, BRC and JMP SHALL last one cycle, then return to FETCH:
- ALU/LDI: RW=1, PI=1.
- JMP: PL=1.
- BRC: PL=COND and PI=~COND.
- Handshake to next IR_READY SHALL be 3 cycles.
REQ-023 EXEC for LD/ST SHALL move to MEM:
- MR (LD) or MW (ST) SHALL stay high every MEM cycle until MEM_DONE=1 is sampled.
- LD then goes to WB with RW=1, MD=1, PI=1 for one cycle, then FETCH.
- ST asserts PI=1 in the MEM_DONE cycle and then goes to FETCH.
REQ-024 A wait counter SHALL clear on MEM entry and increment each MEM cycle without MEM_DONE; on reaching MEM_TIMEOUT the FSM SHALL go to FAULT with FAULT_CODE=10 and drop MR/MW.
REQ-025 MEM_DONE sampled in the same cycle the counter reaches MEM_TIMEOUT SHALL count as completion, not timeout.
REQ-026 FAULT SHALL be absorbing: all strobes 0, IR_READY 0, FAULT=1, until RST.
REQ-027 RW, MR, MW, PL and PI SHALL never be asserted outside EXEC/MEM/WB, and PL and PI SHALL never both be 1.

Reset
REQ-028 RST, in any state including MEM and FAULT, SHALL force FETCH on the next edge and clear the latched IR, the counter, FAULT and FAULT_CODE.
REQ-029 Reset values: IR_READY=1; every other output 0, including KNS.
REQ-030 IR_VALID during RST SHALL be ignored, and no handshake SHALL occur in a reset cycle.

Verification
REQ-031 ADDI: IR=0x0901 handshake -> DECODE DA=AA=1, KNS=0x0001, MB=1; EXEC RW=1, PI=1; IR_READY back 3 cycles after handshake.
REQ-032 Sign extension: LDI IR=0xDC00 -> DA=3, KNS=0xFC00 with SEXT=1 and 0x0400 with SEXT=0.
REQ-033 LD IR=0x8048 with MEM_DONE after 4 cycles -> MR high for exactly 4 cycles, then one WB cycle with RW=MD=PI=1, DA=1, AA=1.
REQ-034 ST with MEM_DONE held 0 and MEM_TIMEOUT=15 -> MW high 15 cycles, then FAULT=1, FAULT_CODE=10, strobes 0 and IR_READY 0 until RST.
REQ-035 Illegal IR=0x0000 -> FAULT_CODE=01. BRC IR=0xA005: COND=1 -> PL=1, KNS=5, PI=0; COND=0 -> PI=1, PL=0.
REQ-036 RST asserted in the second MEM cycle -> next cycle all strobes 0 and IR_READY=1; the following handshake then executes normally.
